nreno_timeout_engine: RTL and testbench
=======================================

# nreno_timeout_engine

Multi-flow NewReno retransmission-timeout engine for the nreno congestion-control path. Accepts one timeout event per cycle from the timer wheel, keeps per-flow congestion context internally (ssthresh, backoff count, recover point, timeout flag), applies exponential RTO backoff with a give-up limit, and presents a registered retransmit decision to the data-path scheduler over a valid/ready handshake. A separate clear port from the ACK path resets a flow's backoff state when new data is acknowledged.

## Interface
- NUM_FLOWS, 16: flows tracked; flow id width FID_W = clogb2(NUM_FLOWS)
- SEQ_W, 32: sequence number width
- WIN_W, 9: window-size width
- TIMER_W, 16: timer width
- MAX_BACKOFF, 6: consecutive timeouts before give-up
- RTO_MAX, 16'hFFFF: RTO ceiling
- SSTHRESH_INIT, 9'h1FF: ssthresh after reset and after a full clear
- RTX_MODE, 0: 0 = retransmit first segment only; 1 = go-back-N (wnd_start up to next_new)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- to_valid  in  1  timeout event present
- to_ready  out  1  engine can accept an event
- to_fid  in  FID_W  flow of the event
- to_wnd_start  in  SEQ_W  oldest unacked seq
- to_next_new  in  SEQ_W  next never-sent seq
- to_wnd_size  in  WIN_W  current cwnd
- to_rto_base  in  TIMER_W  unbacked-off RTO
- clr_valid  in  1  clear request from ACK path (never stalled)
- clr_fid  in  FID_W  flow to clear
- clr_full  in  1  also reset ssthresh and recover (new connection)
- out_valid / out_ready  out / in  1  decision handshake
- out_fid  out  FID_W
- out_mark_rtx  out  1  retransmit range valid
- out_rtx_start, out_rtx_end  out  SEQ_W  range, end exclusive
- out_wnd_size  out  WIN_W  new cwnd
- out_rto  out  TIMER_W  backed-off RTO to rearm
- out_ss_thresh, out_recover  out  WIN_W, SEQ_W  updated context
- out_backoff  out  clogb2(MAX_BACKOFF+1)  updated backoff count
- out_give_up  out  1  flow exceeded MAX_BACKOFF

## Operation
- Per-flow context table in registers: backoff, in_timeout, ss_thresh, recover. Read combinationally at acceptance.
- Clear (clr_valid): backoff<=0, in_timeout<=0; with clr_full also ss_thresh<=SSTHRESH_INIT, recover<=0. Applied every cycle it is asserted.
- Accepted event (to_valid & to_ready), context c of to_fid (after bypass below):
  - give_up case (c.backoff == MAX_BACKOFF): out_give_up=1, out_mark_rtx=0, out_wnd_size=to_wnd_size, out_rto=RTO_MAX; context unchanged.
  - otherwise: b = c.backoff+1; out_rto = min(to_rto_base << b, RTO_MAX), computed at TIMER_W+MAX_BACKOFF bits then clamped; out_wnd_size=1.
  - ss_thresh recomputed only when c.in_timeout==0: max(to_wnd_size>>1, 2); else kept. recover = to_next_new-1 (mod 2^SEQ_W). in_timeout<=1, backoff<=b.
  - range: RTX_MODE 0 -> [wnd_start, wnd_start+1); mode 1 -> [wnd_start, next_new). All sums mod 2^SEQ_W.
  - to_next_new == to_wnd_start (nothing outstanding): out_mark_rtx=0, context still updated.
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1). to_ready = EMPTY | out_ready. Accept moves to/stays FULL; out_ready without accept -> EMPTY.

## Timing
- Reset: out_valid=0, all out_* = 0, to_ready=1 in the cycle after rst deasserts; table: backoff=0, in_timeout=0, ss_thresh=SSTHRESH_INIT, recover=0. rst asserted mid-operation discards a held decision.
- Latency: event accepted at edge N -> table written at N, decision valid from N+1; held stable until out_ready.
- Throughput: one event per cycle while out_ready=1.
- Clear and accepted event to same flow in same cycle: clear bypasses into the read (event sees cleared context, result b=1); event's write wins for the written fields.
- Back-to-back events to same flow: second reads the first's written context (table written at edge).
- to_* ignored when to_ready=0; upstream holds them.

## Test plan
- Reset, single event fid 3, wnd_start=100, next_new=110, wnd_size=20, rto_base=8 -> N+1: mark_rtx=1, range [100,101), wnd 1, ss_thresh 10, recover 109, rto 16, backoff 1.
- Three consecutive events fid 3 -> rto 16, 32, 64; ss_thresh stays 10; clear fid 3 then event -> rto 16, ss_thresh recomputed.
- MAX_BACKOFF+1 events on one flow -> last gives out_give_up=1, mark_rtx=0, out_rto=RTO_MAX; rto_base=16'h4000, backoff 3 -> clamps to RTO_MAX.
- RTX_MODE 1, wnd_start=32'hFFFF_FFFE, next_new=2 -> range [FFFF_FFFE, 2), recover 1; next_new==wnd_start -> mark_rtx=0.
- Same-cycle clear+event fid 5 (backoff 4) -> backoff_out 1; out_ready held 0 for 3 cycles -> outputs stable, to_ready=0, no event lost.
- rst asserted while FULL -> out_valid 0 next cycle, table reinitialised.

Source files
------------

// File: rtl/nreno_timeout_engine_if.sv
// ---------------------------------------------------------------------------
// nreno_timeout_engine_if
//
// Bundles the three channels of the NewReno timeout engine:
//   to_*   : timeout events from the timer wheel (valid/ready)
//   clr_*  : backoff clear requests from the ACK path (valid only, never stalled)
//   out_*  : registered retransmit decision to the scheduler (valid/ready)
//
// Modports:
//   master : the side that issues timeout events and clears and consumes
//            decisions (timer wheel / ACK path / scheduler, or a bench)
//   slave  : the engine itself
// ---------------------------------------------------------------------------
interface nreno_timeout_engine_if #(
  parameter int NUM_FLOWS   = 16,
  parameter int SEQ_W       = 32,
  parameter int WIN_W       = 9,
  parameter int TIMER_W     = 16,
  parameter int MAX_BACKOFF = 6
);

  localparam int FID_W = $clog2(NUM_FLOWS);
  localparam int BO_W  = $clog2(MAX_BACKOFF + 1);

  // timeout event channel
  logic               to_valid;
  logic               to_ready;
  logic [FID_W-1:0]   to_fid;
  logic [SEQ_W-1:0]   to_wnd_start;
  logic [SEQ_W-1:0]   to_next_new;
  logic [WIN_W-1:0]   to_wnd_size;
  logic [TIMER_W-1:0] to_rto_base;

  // clear channel
  logic               clr_valid;
  logic [FID_W-1:0]   clr_fid;
  logic               clr_full;

  // decision channel
  logic               out_valid;
  logic               out_ready;
  logic [FID_W-1:0]   out_fid;
  logic               out_mark_rtx;
  logic [SEQ_W-1:0]   out_rtx_start;
  logic [SEQ_W-1:0]   out_rtx_end;
  logic [WIN_W-1:0]   out_wnd_size;
  logic [TIMER_W-1:0] out_rto;
  logic [WIN_W-1:0]   out_ss_thresh;
  logic [SEQ_W-1:0]   out_recover;
  logic [BO_W-1:0]    out_backoff;
  logic               out_give_up;

  modport master (
    output to_valid, to_fid, to_wnd_start, to_next_new, to_wnd_size, to_rto_base,
    input  to_ready,
    output clr_valid, clr_fid, clr_full,
    input  out_valid, out_fid, out_mark_rtx, out_rtx_start, out_rtx_end,
    input  out_wnd_size, out_rto, out_ss_thresh, out_recover, out_backoff, out_give_up,
    output out_ready
  );

  modport slave (
    input  to_valid, to_fid, to_wnd_start, to_next_new, to_wnd_size, to_rto_base,
    output to_ready,
    input  clr_valid, clr_fid, clr_full,
    output out_valid, out_fid, out_mark_rtx, out_rtx_start, out_rtx_end,
    output out_wnd_size, out_rto, out_ss_thresh, out_recover, out_backoff, out_give_up,
    input  out_ready
  );

endinterface

// File: rtl/nreno_timeout_engine.sv
// ---------------------------------------------------------------------------
// nreno_timeout_engine
//
// Multi-flow NewReno retransmission-timeout engine. Each accepted timeout
// event looks up the flow's congestion context (backoff count, in-timeout
// flag, ssthresh, recover point), applies exponential RTO backoff with a
// give-up limit, updates the context and presents a one-entry registered
// decision to the scheduler. The ACK path can clear a flow's backoff state
// at any time; a clear to the same flow as a same-cycle event is bypassed
// into that event's context read.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (table and output register)
//   bus  : nreno_timeout_engine_if.slave
//          to_*  in  timeout event (to_ready out)
//          clr_* in  clear request, honoured every cycle it is asserted
//          out_* out registered decision (out_ready in)
// ---------------------------------------------------------------------------
module nreno_timeout_engine #(
  parameter int                 NUM_FLOWS     = 16,
  parameter int                 SEQ_W         = 32,
  parameter int                 WIN_W         = 9,
  parameter int                 TIMER_W       = 16,
  parameter int                 MAX_BACKOFF   = 6,
  parameter logic [TIMER_W-1:0] RTO_MAX       = {TIMER_W{1'b1}},
  parameter logic [WIN_W-1:0]   SSTHRESH_INIT = {WIN_W{1'b1}},
  parameter int                 RTX_MODE      = 0
) (
  input logic                  clk,
  input logic                  rst,
  nreno_timeout_engine_if.slave bus
);

  localparam int FID_W  = $clog2(NUM_FLOWS);
  localparam int BO_W   = $clog2(MAX_BACKOFF + 1);
  localparam int WIDE_W = TIMER_W + MAX_BACKOFF;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // per-flow context table
  logic [BO_W-1:0]  backoff_q    [NUM_FLOWS];
  logic             in_timeout_q [NUM_FLOWS];
  logic [WIN_W-1:0] ss_thresh_q  [NUM_FLOWS];
  logic [SEQ_W-1:0] recover_q    [NUM_FLOWS];

  // decision register
  logic [FID_W-1:0]   out_fid_q;
  logic               out_mark_rtx_q;
  logic [SEQ_W-1:0]   out_rtx_start_q;
  logic [SEQ_W-1:0]   out_rtx_end_q;
  logic [WIN_W-1:0]   out_wnd_size_q;
  logic [TIMER_W-1:0] out_rto_q;
  logic [WIN_W-1:0]   out_ss_thresh_q;
  logic [SEQ_W-1:0]   out_recover_q;
  logic [BO_W-1:0]    out_backoff_q;
  logic               out_give_up_q;

  logic               accept;
  logic               clr_hit;
  logic [BO_W-1:0]    cur_backoff;
  logic               cur_in_timeout;
  logic [WIN_W-1:0]   cur_ss_thresh;
  logic [SEQ_W-1:0]   cur_recover;

  logic               give_up;
  logic               nothing_outstanding;
  logic [BO_W-1:0]    new_backoff;
  logic [WIDE_W-1:0]  rto_wide;
  logic [TIMER_W-1:0] new_rto;
  logic [WIN_W-1:0]   half_wnd;
  logic [WIN_W-1:0]   new_ss_thresh;
  logic [SEQ_W-1:0]   new_recover;
  logic [SEQ_W-1:0]   rtx_end;

  // The output register can take a new decision when empty, or when the
  // held one leaves in this same cycle.
  assign bus.to_ready = (state_q == S_EMPTY) || bus.out_ready;
  assign accept       = bus.to_valid && bus.to_ready;

  // Context read with clear bypass: a same-cycle clear to the event's flow
  // is visible to the event, so it starts again from backoff 0.
  always_comb begin
    clr_hit        = bus.clr_valid && (bus.clr_fid == bus.to_fid);
    cur_backoff    = backoff_q[bus.to_fid];
    cur_in_timeout = in_timeout_q[bus.to_fid];
    cur_ss_thresh  = ss_thresh_q[bus.to_fid];
    cur_recover    = recover_q[bus.to_fid];
    if (clr_hit) begin
      cur_backoff    = '0;
      cur_in_timeout = 1'b0;
      if (bus.clr_full) begin
        cur_ss_thresh = SSTHRESH_INIT;
        cur_recover   = '0;
      end
    end
  end

  // Decision arithmetic. The shifted RTO is formed wide enough that the
  // largest backoff cannot overflow, then clamped to the ceiling.
  always_comb begin
    give_up             = (cur_backoff == BO_W'(MAX_BACKOFF));
    new_backoff         = cur_backoff + BO_W'(1);
    rto_wide            = {{MAX_BACKOFF{1'b0}}, bus.to_rto_base} << new_backoff;
    new_rto             = (rto_wide > WIDE_W'(RTO_MAX)) ? RTO_MAX : rto_wide[TIMER_W-1:0];
    half_wnd            = bus.to_wnd_size >> 1;
    new_ss_thresh       = cur_ss_thresh;
    if (!cur_in_timeout) begin
      new_ss_thresh = (half_wnd < WIN_W'(2)) ? WIN_W'(2) : half_wnd;
    end
    new_recover         = bus.to_next_new - SEQ_W'(1);
    nothing_outstanding = (bus.to_next_new == bus.to_wnd_start);
    if (RTX_MODE == 1) begin
      rtx_end = bus.to_next_new;
    end else begin
      rtx_end = bus.to_wnd_start + SEQ_W'(1);
    end
  end

  // Context table update. The clear is applied first and an accepted,
  // non-give-up event to the same flow then overwrites every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        backoff_q[i]    <= '0;
        in_timeout_q[i] <= 1'b0;
        ss_thresh_q[i]  <= SSTHRESH_INIT;
        recover_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (bus.clr_valid && (bus.clr_fid == FID_W'(i))) begin
          backoff_q[i]    <= '0;
          in_timeout_q[i] <= 1'b0;
          if (bus.clr_full) begin
            ss_thresh_q[i] <= SSTHRESH_INIT;
            recover_q[i]   <= '0;
          end
        end
        if (accept && !give_up && (bus.to_fid == FID_W'(i))) begin
          backoff_q[i]    <= new_backoff;
          in_timeout_q[i] <= 1'b1;
          ss_thresh_q[i]  <= new_ss_thresh;
          recover_q[i]    <= new_recover;
        end
      end
    end
  end

  // Output register occupancy: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register occupancy: next state. A new decision always lands in
  // the register; otherwise a consumed decision empties it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = S_FULL;
    end else if (bus.out_ready) begin
      state_d = S_EMPTY;
    end
  end

  // Decision payload, loaded on acceptance and held until the next one.
  // On give-up the context is reported unchanged and the RTO is pinned.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_fid_q       <= '0;
      out_mark_rtx_q  <= 1'b0;
      out_rtx_start_q <= '0;
      out_rtx_end_q   <= '0;
      out_wnd_size_q  <= '0;
      out_rto_q       <= '0;
      out_ss_thresh_q <= '0;
      out_recover_q   <= '0;
      out_backoff_q   <= '0;
      out_give_up_q   <= 1'b0;
    end else if (accept) begin
      out_fid_q       <= bus.to_fid;
      out_rtx_start_q <= bus.to_wnd_start;
      out_rtx_end_q   <= rtx_end;
      if (give_up) begin
        out_mark_rtx_q  <= 1'b0;
        out_wnd_size_q  <= bus.to_wnd_size;
        out_rto_q       <= RTO_MAX;
        out_ss_thresh_q <= cur_ss_thresh;
        out_recover_q   <= cur_recover;
        out_backoff_q   <= cur_backoff;
        out_give_up_q   <= 1'b1;
      end else begin
        out_mark_rtx_q  <= !nothing_outstanding;
        out_wnd_size_q  <= WIN_W'(1);
        out_rto_q       <= new_rto;
        out_ss_thresh_q <= new_ss_thresh;
        out_recover_q   <= new_recover;
        out_backoff_q   <= new_backoff;
        out_give_up_q   <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = (state_q == S_FULL);
  assign bus.out_fid       = out_fid_q;
  assign bus.out_mark_rtx  = out_mark_rtx_q;
  assign bus.out_rtx_start = out_rtx_start_q;
  assign bus.out_rtx_end   = out_rtx_end_q;
  assign bus.out_wnd_size  = out_wnd_size_q;
  assign bus.out_rto       = out_rto_q;
  assign bus.out_ss_thresh = out_ss_thresh_q;
  assign bus.out_recover   = out_recover_q;
  assign bus.out_backoff   = out_backoff_q;
  assign bus.out_give_up   = out_give_up_q;

endmodule

// File: tb/tb_nreno_timeout_engine.sv
// ---------------------------------------------------------------------------
// tb_nreno_timeout_engine
//
// Drives two engines (retransmit-first and go-back-N) with identical
// stimulus. A reference model of the per-flow context predicts each decision
// at the moment the event is accepted and queues it; a monitor pops and
// compares whenever a decision is consumed, and checks hold behaviour while
// the scheduler stalls.
// ---------------------------------------------------------------------------
module tb_nreno_timeout_engine;

  localparam int NFL = 16;

  typedef struct {
    logic [3:0]  fid;
    bit          mark;
    logic [31:0] start;
    logic [31:0] end0;
    logic [31:0] end1;
    logic [8:0]  wnd;
    logic [15:0] rto;
    logic [8:0]  ss;
    logic [31:0] rec;
    logic [2:0]  bo;
    bit          gu;
  } exp_t;

  logic clk;
  logic rst;

  nreno_timeout_engine_if if0 ();
  nreno_timeout_engine_if if1 ();

  nreno_timeout_engine #(.RTX_MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  nreno_timeout_engine #(.RTX_MODE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // the go-back-N engine sees exactly the same inputs
  assign if1.to_valid     = if0.to_valid;
  assign if1.to_fid       = if0.to_fid;
  assign if1.to_wnd_start = if0.to_wnd_start;
  assign if1.to_next_new  = if0.to_next_new;
  assign if1.to_wnd_size  = if0.to_wnd_size;
  assign if1.to_rto_base  = if0.to_rto_base;
  assign if1.clr_valid    = if0.clr_valid;
  assign if1.clr_fid      = if0.clr_fid;
  assign if1.clr_full     = if0.clr_full;
  assign if1.out_ready    = if0.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // reference model of the per-flow context
  int          m_bo  [NFL];
  bit          m_to  [NFL];
  logic [8:0]  m_ss  [NFL];
  logic [31:0] m_rec [NFL];

  int stall_left = 0;
  bit rand_ready = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s got %0h expected %0h", name, got, want);
  endtask

  task automatic modelInit();
    for (int i = 0; i < NFL; i++) begin
      m_bo[i] = 0; m_to[i] = 0; m_ss[i] = 9'h1FF; m_rec[i] = 0;
    end
  endtask

  task automatic modelClear(input int f, input bit full);
    m_bo[f] = 0;
    m_to[f] = 0;
    if (full) begin
      m_ss[f]  = 9'h1FF;
      m_rec[f] = 0;
    end
  endtask

  // Predict the decision for an accepted event and update the context.
  task automatic modelEvent(input int f, input logic [31:0] ws, input logic [31:0] nn,
                            input logic [8:0] wsz, input logic [15:0] base);
    exp_t   e;
    int     b;
    int     h;
    longint r;
    e.fid = 4'(f); e.start = ws; e.end0 = ws + 32'd1; e.end1 = nn;
    if (m_bo[f] == 6) begin
      e.gu = 1; e.mark = 0; e.wnd = wsz; e.rto = 16'hFFFF;
      e.ss = m_ss[f]; e.rec = m_rec[f]; e.bo = 3'd6;
    end else begin
      b = m_bo[f] + 1;
      r = longint'(base) * (longint'(1) << b);
      if (r > 65535) r = 65535;
      if (!m_to[f]) begin
        h = int'(wsz) / 2;
        if (h < 2) h = 2;
        m_ss[f] = 9'(h);
      end
      m_rec[f] = nn - 32'd1;
      m_to[f]  = 1;
      m_bo[f]  = b;
      e.gu = 0; e.mark = (nn != ws); e.wnd = 9'd1; e.rto = 16'(r);
      e.ss = m_ss[f]; e.rec = m_rec[f]; e.bo = 3'(b);
    end
    exp_q.push_back(e);
  endtask

  task automatic setReady();
    if (stall_left > 0) begin
      if0.out_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      if0.out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      if0.out_ready = 1'b1;
    end
  endtask

  // Present one event (optionally with a first-cycle clear) and hold it
  // until the engine accepts it.
  task automatic applyStimulus(input int f, input logic [31:0] ws, input logic [31:0] nn,
                               input logic [8:0] wsz, input logic [15:0] base,
                               input bit do_clr, input int cf, input bit cfull);
    bit done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      setReady();
      if0.to_valid     = 1'b1;
      if0.to_fid       = 4'(f);
      if0.to_wnd_start = ws;
      if0.to_next_new  = nn;
      if0.to_wnd_size  = wsz;
      if0.to_rto_base  = base;
      if0.clr_valid    = (k == 0) && do_clr;
      if0.clr_fid      = 4'(cf);
      if0.clr_full     = cfull;
      #1;
      if (k == 0 && do_clr) modelClear(cf, cfull);
      if (if0.to_ready) begin
        modelEvent(f, ws, nn, wsz, base);
        done = 1;
      end
    end
    if (!done) checkOutput("accept_timeout", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    if0.to_valid  = 1'b0;
    if0.clr_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n, input bit rand_clr);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      setReady();
      if0.to_valid = 1'b0;
      if (rand_clr && $urandom_range(0, 3) == 0) begin
        if0.clr_valid = 1'b1;
        if0.clr_fid   = 4'($urandom_range(0, 3));
        if0.clr_full  = 1'($urandom_range(0, 1));
        modelClear(int'(if0.clr_fid), if0.clr_full);
      end else begin
        if0.clr_valid = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    if0.to_valid  = 1'b0;
    if0.clr_valid = 1'b0;
    if0.out_ready = 1'b0;
    stall_left    = 0;
    exp_q.delete();
    modelInit();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid0", 64'(if0.out_valid), 64'd0);
    checkOutput("rst_out_valid1", 64'(if1.out_valid), 64'd0);
    checkOutput("rst_to_ready", 64'(if0.to_ready), 64'd1);
    checkOutput("rst_out_rto", 64'(if0.out_rto), 64'd0);
    checkOutput("rst_out_fid", 64'(if0.out_fid), 64'd0);
    checkOutput("rst_out_backoff", 64'(if0.out_backoff), 64'd0);
    checkOutput("rst_out_ss", 64'(if1.out_ss_thresh), 64'd0);
    checkOutput("rst_out_end", 64'(if1.out_rtx_end), 64'd0);
  endtask

  task automatic checkDecision(input string tag, input exp_t e, input logic [31:0] want_end,
                               input logic [3:0] fid, input logic mark,
                               input logic [31:0] st, input logic [31:0] en,
                               input logic [8:0] wnd, input logic [15:0] rto,
                               input logic [8:0] ss, input logic [31:0] rec,
                               input logic [2:0] bo, input logic gu);
    checkOutput({tag, "_fid"}, 64'(fid), 64'(e.fid));
    checkOutput({tag, "_mark_rtx"}, 64'(mark), 64'(e.mark));
    checkOutput({tag, "_wnd"}, 64'(wnd), 64'(e.wnd));
    checkOutput({tag, "_rto"}, 64'(rto), 64'(e.rto));
    checkOutput({tag, "_ss_thresh"}, 64'(ss), 64'(e.ss));
    checkOutput({tag, "_recover"}, 64'(rec), 64'(e.rec));
    checkOutput({tag, "_backoff"}, 64'(bo), 64'(e.bo));
    checkOutput({tag, "_give_up"}, 64'(gu), 64'(e.gu));
    if (e.mark) begin
      checkOutput({tag, "_rtx_start"}, 64'(st), 64'(e.start));
      checkOutput({tag, "_rtx_end"}, 64'(en), 64'(want_end));
    end
  endtask

  // Monitor: compares each decision as it is consumed and checks that a
  // stalled decision holds and back-pressures the event channel.
  initial begin
    exp_t        e;
    bit          prev_stall = 0;
    logic [15:0] prev_rto   = '0;
    logic [3:0]  prev_fid   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 0;
        continue;
      end
      if (if0.out_valid) begin
        if (if0.out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("spurious_out_valid", 64'(if0.out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("dut1_out_valid", 64'(if1.out_valid), 64'd1);
            checkDecision("dut0", e, e.end0, if0.out_fid, if0.out_mark_rtx, if0.out_rtx_start,
                          if0.out_rtx_end, if0.out_wnd_size, if0.out_rto, if0.out_ss_thresh,
                          if0.out_recover, if0.out_backoff, if0.out_give_up);
            checkDecision("dut1", e, e.end1, if1.out_fid, if1.out_mark_rtx, if1.out_rtx_start,
                          if1.out_rtx_end, if1.out_wnd_size, if1.out_rto, if1.out_ss_thresh,
                          if1.out_recover, if1.out_backoff, if1.out_give_up);
          end
          prev_stall = 0;
        end else begin
          checkOutput("stall_to_ready", 64'(if0.to_ready), 64'd0);
          if (prev_stall) begin
            checkOutput("stall_rto_stable", 64'(if0.out_rto), 64'(prev_rto));
            checkOutput("stall_fid_stable", 64'(if0.out_fid), 64'(prev_fid));
          end
          prev_stall = 1;
          prev_rto   = if0.out_rto;
          prev_fid   = if0.out_fid;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ws;
    logic [31:0] nn;
    rst              = 1'b1;
    if0.to_valid     = 1'b0;
    if0.to_fid       = '0;
    if0.to_wnd_start = '0;
    if0.to_next_new  = '0;
    if0.to_wnd_size  = '0;
    if0.to_rto_base  = '0;
    if0.clr_valid    = 1'b0;
    if0.clr_fid      = '0;
    if0.clr_full     = 1'b0;
    if0.out_ready    = 1'b0;
    modelInit();
    doReset();

    $display("[TB] single event and consecutive backoff on flow 3");
    applyStimulus(3, 32'd100, 32'd110, 9'd20, 16'd8, 0, 0, 0);
    applyStimulus(3, 32'd100, 32'd110, 9'd20, 16'd8, 0, 0, 0);
    applyStimulus(3, 32'd100, 32'd110, 9'd40, 16'd8, 0, 0, 0);
    idleCycles(1, 0);
    @(negedge clk);
    if0.clr_valid = 1'b1; if0.clr_fid = 4'd3; if0.clr_full = 1'b0;
    modelClear(3, 0);
    applyStimulus(3, 32'd200, 32'd230, 9'd30, 16'd8, 0, 0, 0);

    $display("[TB] RTO clamp and give-up");
    for (int k = 0; k < 3; k++) applyStimulus(1, 32'd5, 32'd9, 9'd12, 16'h4000, 0, 0, 0);
    for (int k = 0; k < 8; k++) applyStimulus(7, 32'd50, 32'd60, 9'd16, 16'd8, 0, 0, 0);

    $display("[TB] sequence wrap and nothing outstanding");
    applyStimulus(9, 32'hFFFF_FFFE, 32'd2, 9'd3, 16'd100, 0, 0, 0);
    applyStimulus(10, 32'd77, 32'd77, 9'd1, 16'd100, 0, 0, 0);

    $display("[TB] same-cycle clear and event on flow 5");
    for (int k = 0; k < 4; k++) applyStimulus(5, 32'd10, 32'd20, 9'd8, 16'd3, 0, 0, 0);
    applyStimulus(5, 32'd10, 32'd20, 9'd8, 16'd3, 1, 5, 0);
    applyStimulus(5, 32'd10, 32'd20, 9'd8, 16'd3, 1, 5, 1);

    $display("[TB] scheduler stall");
    stall_left = 4;
    applyStimulus(6, 32'd1000, 32'd1004, 9'd10, 16'd20, 0, 0, 0);
    applyStimulus(6, 32'd1000, 32'd1004, 9'd10, 16'd20, 0, 0, 0);
    idleCycles(2, 0);

    $display("[TB] randomized traffic");
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      ws = $urandom;
      nn = ($urandom_range(0, 4) == 0) ? ws : ws + 32'($urandom_range(1, 40));
      applyStimulus($urandom_range(0, 3), ws, nn, 9'($urandom_range(0, 511)),
                    16'($urandom_range(1, 65535) >> $urandom_range(0, 12)),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      idleCycles($urandom_range(0, 2), 1);
    end
    rand_ready = 0;
    idleCycles(4, 0);

    $display("[TB] reset while a decision is held");
    stall_left = 100;
    applyStimulus(2, 32'd300, 32'd310, 9'd20, 16'd8, 0, 0, 0);
    idleCycles(1, 0);
    doReset();
    applyStimulus(3, 32'd100, 32'd110, 9'd20, 16'd8, 0, 0, 0);
    applyStimulus(7, 32'd50, 32'd60, 9'd16, 16'd8, 0, 0, 0);

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) idleCycles(1, 0);
    idleCycles(2, 0);
    checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
